// File: rtl/memoria_pkg.sv
// Shared definitions for memoria_param: FSM state encoding, default parameters and
// the address-width helper used by the register bank.
package memoria_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEF_DATA_W   = 4;
    localparam int          DEF_ADDR_W   = 3;
    localparam int          DEF_DEPTH    = 7;
    localparam int          DEF_LATENCY  = 2;
    localparam logic [31:0] DEF_INIT_VAL = 32'hA;

    // A one-word bank still needs a 1-bit address port.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/banco_registros.sv
// Register bank: DEPTH words of DATA_W bits, all reloaded with INIT_VAL on reset,
// one synchronous write port and one combinational read port.
module banco_registros
    import memoria_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [31:0] INIT_VAL = DEF_INIT_VAL,
    parameter int          AW       = addr_bits(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [DATA_W-1:0] INIT_W = INIT_VAL[DATA_W-1:0];

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_W;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Callers only use rdata for addresses below DEPTH.
    assign rdata = mem[addr];

endmodule

// File: rtl/memoria_param.sv
// Latency-configurable word memory: request captured in IDLE, access after LATENCY
// edges, one-cycle confirma pulse. Define MEMORIA_STATS_EN for read/write counters.
module memoria_param
    import memoria_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter int          LATENCY  = DEF_LATENCY,
    parameter logic [31:0] INIT_VAL = DEF_INIT_VAL
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              writeback,
    input  logic [ADDR_W-1:0] tag,
    input  logic [DATA_W-1:0] entrada,
    output logic [DATA_W-1:0] saida,
    output logic              confirma,
    output logic              erro_tag,
    output logic              ocupado,
`ifdef MEMORIA_STATS_EN
    output logic [15:0]       n_leituras,
    output logic [15:0]       n_escritas,
`endif
    output state_t            fsm_state
);

    // Handshake: req is sampled only while IDLE; confirma is high for exactly the
    // DONE cycle, and ocupado is high in every state except IDLE.
    localparam int                CNT_W   = $clog2(LATENCY + 1);
    localparam int                BANK_AW = addr_bits(DEPTH);
    localparam logic [CNT_W-1:0]  LAT_M1  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               capture, access;
    logic               wb_q;
    logic [ADDR_W-1:0]  tag_q;
    logic [DATA_W-1:0]  data_q;
    logic               tag_ok;
    logic [DATA_W-1:0]  rdata;

    assign tag_ok = {1'b0, tag_q} < DEPTH_L;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            saida   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                wb_q   <= writeback;
                tag_q  <= tag;
                data_q <= entrada;
            end
            if (access && !wb_q && tag_ok) begin
                saida <= rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                    capture = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    banco_registros #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL),
        .AW       (BANK_AW)
    ) u_banco (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (access && wb_q && tag_ok),
        .addr    (tag_q[BANK_AW-1:0]),
        .wdata   (data_q),
        .rdata   (rdata)
    );

    assign confirma  = (state_q == DONE);
    assign erro_tag  = (state_q == DONE) && !tag_ok;
    assign ocupado   = (state_q != IDLE);
    assign fsm_state = state_q;

`ifdef MEMORIA_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            n_leituras <= '0;
            n_escritas <= '0;
        end else if (state_q == DONE && tag_ok) begin
            if (!wb_q && n_leituras != 16'hFFFF) n_leituras <= n_leituras + 16'd1;
            if (wb_q && n_escritas != 16'hFFFF)  n_escritas <= n_escritas + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memoria_param.sv
// Directed bench for memoria_param at default parameters (DATA_W=4, DEPTH=7, LATENCY=2).
module tb_memoria_param;
    import memoria_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic       writeback = 1'b0;
    logic [2:0] tag = '0;
    logic [3:0] entrada = '0;
    logic [3:0] saida;
    logic       confirma, erro_tag, ocupado;
    state_t     fsm_state;
`ifdef MEMORIA_STATS_EN
    logic [15:0] n_leituras, n_escritas;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    memoria_param dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .writeback (writeback),
        .tag       (tag),
        .entrada   (entrada),
        .saida     (saida),
        .confirma  (confirma),
        .erro_tag  (erro_tag),
        .ocupado   (ocupado),
`ifdef MEMORIA_STATS_EN
        .n_leituras(n_leituras),
        .n_escritas(n_escritas),
`endif
        .fsm_state (fsm_state)
    );

    // One request; lat = edges after acceptance until confirma seen (-1 if never),
    // pulses = confirma-high cycles in a 6-cycle window, err = erro_tag with first confirma.
    task automatic run_access(input logic wb, input logic [2:0] t, input logic [3:0] d,
                              output int lat, output int pulses, output logic err);
        lat = -1; pulses = 0; err = 1'b0;
        @(negedge clock);
        req = 1'b1; writeback = wb; tag = t; entrada = d;
        @(posedge clock); #1;
        req = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock); #1;
            if (confirma) begin
                pulses++;
                if (lat < 0) begin
                    lat = i;
                    err = erro_tag;
                end
            end
        end
    endtask

    task automatic check_access(input string name, input int lat, input int pulses,
                                input logic err, input logic exp_err);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 2", name, lat);
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL %s confirma pulses: got %0d expected 1", name, pulses);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s erro_tag: got %0b expected %0b", name, err, exp_err);
        end
    endtask

    task automatic check_saida(input string name, input logic [3:0] exp);
        n_checks++;
        if (saida !== exp) begin
            n_fail++;
            $display("FAIL %s saida: got %h expected %h", name, saida, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({ocupado, confirma, erro_tag, saida} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got ocup=%b conf=%b err=%b saida=%h expected all 0",
                     ocupado, confirma, erro_tag, saida);
        end
        n_checks++;
        if (fsm_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset state: got %0d expected %0d", fsm_state, IDLE);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_read_after_reset();
        int lat, pulses; logic err;
        run_access(1'b0, 3'd3, 4'h0, lat, pulses, err);
        check_access("read_after_reset", lat, pulses, err, 1'b0);
        check_saida("read_after_reset", 4'hA);
    endtask

    task automatic test_write_read();
        int lat, pulses; logic err;
        run_access(1'b1, 3'd5, 4'h3, lat, pulses, err);
        check_access("write5", lat, pulses, err, 1'b0);
        run_access(1'b0, 3'd5, 4'h0, lat, pulses, err);
        check_access("read5", lat, pulses, err, 1'b0);
        check_saida("read5", 4'h3);
        run_access(1'b1, 3'd6, 4'hC, lat, pulses, err);
        check_access("write6", lat, pulses, err, 1'b0);
        run_access(1'b0, 3'd6, 4'h0, lat, pulses, err);
        check_access("read6", lat, pulses, err, 1'b0);
        check_saida("read6", 4'hC);
    endtask

    task automatic test_invalid_tag();
        int lat, pulses; logic err;
        logic [3:0] exp_mem [7];
        exp_mem = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h3, 4'hC};
        run_access(1'b0, 3'd7, 4'h0, lat, pulses, err);
        check_access("read7", lat, pulses, err, 1'b1);
        check_saida("read7_unchanged", 4'hC);
        run_access(1'b1, 3'd7, 4'h5, lat, pulses, err);
        check_access("write7", lat, pulses, err, 1'b1);
        for (int i = 0; i < 7; i++) begin
            run_access(1'b0, 3'(i), 4'h0, lat, pulses, err);
            n_checks++;
            if (saida !== exp_mem[i] || lat !== 2) begin
                n_fail++;
                $display("FAIL scan tag%0d: got saida=%h lat=%0d expected saida=%h lat=2",
                         i, saida, lat, exp_mem[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, pulses; logic err;
        logic [12:0] seen;
        seen = '0;
        @(negedge clock);
        req = 1'b1; writeback = 1'b1; tag = 3'd1; entrada = 4'h6;
        @(posedge clock); #1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock); #1;
            seen[i] = confirma;
            if (i == 10) check_saida("busy_read1", 4'h6);
            if (i == 1) begin
                tag = 3'd2; entrada = 4'h9;
            end
            if (i == 5) begin
                writeback = 1'b0; tag = 3'd1; entrada = 4'hF;
            end
            if (i == 9) req = 1'b0;
        end
        n_checks++;
        if (seen !== 13'b0_0100_0100_0100) begin
            n_fail++;
            $display("FAIL busy_ignore confirma cycles: got %b expected %b",
                     seen, 13'b0_0100_0100_0100);
        end
        run_access(1'b0, 3'd2, 4'h0, lat, pulses, err);
        check_access("busy_read2", lat, pulses, err, 1'b0);
        check_saida("busy_read2", 4'h9);
    endtask

    task automatic test_reset_mid_access();
        int lat, pulses; logic err;
        int conf_seen;
        conf_seen = 0;
        @(negedge clock);
        req = 1'b1; writeback = 1'b1; tag = 3'd0; entrada = 4'h1;
        @(posedge clock); #1;
        req = 1'b0;
        n_checks++;
        if (ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset ocupado before reset: got %b expected 1", ocupado);
        end
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if ({ocupado, confirma, saida} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset outputs: got ocup=%b conf=%b saida=%h expected 0",
                     ocupado, confirma, saida);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (confirma) conf_seen++;
        end
        n_checks++;
        if (conf_seen !== 0) begin
            n_fail++;
            $display("FAIL midreset confirma: got %0d pulses expected 0", conf_seen);
        end
        run_access(1'b0, 3'd0, 4'h0, lat, pulses, err);
        check_access("midreset_read0", lat, pulses, err, 1'b0);
        check_saida("midreset_read0", 4'hA);
        run_access(1'b0, 3'd1, 4'h0, lat, pulses, err);
        check_saida("midreset_read1_reloaded", 4'hA);
    endtask

`ifdef MEMORIA_STATS_EN
    task automatic test_stats();
        int lat, pulses; logic err;
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        run_access(1'b0, 3'd0, 4'h0, lat, pulses, err);
        run_access(1'b0, 3'd1, 4'h0, lat, pulses, err);
        run_access(1'b1, 3'd2, 4'h4, lat, pulses, err);
        run_access(1'b0, 3'd7, 4'h0, lat, pulses, err);
        run_access(1'b1, 3'd3, 4'h5, lat, pulses, err);
        run_access(1'b0, 3'd2, 4'h0, lat, pulses, err);
        n_checks++;
        if (n_leituras !== 16'd3 || n_escritas !== 16'd2) begin
            n_fail++;
            $display("FAIL stats: got reads=%0d writes=%0d expected 3 and 2",
                     n_leituras, n_escritas);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_invalid_tag();
        test_busy_ignore();
        test_reset_mid_access();
`ifdef MEMORIA_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
